smart_home_hvac_ctrl: RTL and testbench
=======================================

# smart_home_hvac_ctrl

Parametrised next-generation smart-home controller: debounces N door sensors, a window sensor and a fire sensor, and arbitrates them by priority in a Moore FSM that drives the buzzers and door indication. A registered hysteresis thermostat on a TEMP_W-bit temperature drives heater and cooler and holds its value between thresholds. Sits between the raw sensor pins and the home display and actuator outputs. All state and outputs are flip-flops; there are no latches.

## Interface
- N_DOORS, 2 — number of door sensors (1..8)
- TEMP_W, 7 — temperature width, unsigned
- HEAT_ON, 50 / HEAT_OFF, 55 — heater turns on at temp ≤ HEAT_ON and off at temp ≥ HEAT_OFF
- COOL_ON, 85 / COOL_OFF, 80 — cooler turns on at temp ≥ COOL_ON and off at temp ≤ COOL_OFF
- Parameter constraints: HEAT_ON < HEAT_OFF < COOL_OFF < COOL_ON. Elaboration fails if violated.
- DEB_CYC, 4 — debounce length in cycles (≥1)
- BUZZ_CYC, 16 — alarm hold length after fire clears (≥1)
- Ports:
  - clk in 1 — single clock, rising edge
  - Rst in 1 — reset, asynchronous, active-low
  - SD in N_DOORS — raw door sensors; 1 = open
  - SW in 1 — raw window sensor; 1 = open
  - SFA in 1 — raw fire sensor; 1 = fire
  - alarm_ack in 1 — synchronous; ends the alarm hold early
  - ST in TEMP_W — temperature
  - door_open out N_DOORS — one-hot: the door currently being serviced
  - door_idx out $clog2(N_DOORS)+1 — index of the serviced door
  - winbuzz out 1
  - alarmbuzz out 1
  - heater out 1
  - cooler out 1
  - display out 3 — state code

## Operation
- **Reset (Rst=0):** all flops clear immediately. state=IDLE, outputs all 0, filtered sensors 0, debounce counters 0, thermostat off.
- **Input conditioning:**
  - Each binary sensor passes through a 2-flop synchroniser, then a debounce stage.
  - The filtered value takes the synced value on the DEB_CYC-th consecutive cycle on which they differ.
  - Any cycle on which they agree clears the counter.
  - ST is registered once; it is not debounced.
- **State codes:** IDLE=000, DOOR=001, WIN=100, FIRE=011, HOLD=101. Unused codes recover to IDLE.
- **Next-state priority,** evaluated every cycle from the filtered inputs:
  1. fire → FIRE
  2. state==HOLD and count>1 and !alarm_ack → HOLD
  3. win → WIN
  4. any door → DOOR
  5. otherwise → IDLE
- **FIRE:**
  - alarmbuzz=1; heater and cooler are forced to 0 and the thermostat state is cleared.
  - When fire drops, go to HOLD and load count=BUZZ_CYC.
- **HOLD:**
  - alarmbuzz=1; heater and cooler stay forced to 0.
  - count decrements each cycle.
  - Leave HOLD through the priority list when count==1 or alarm_ack=1.
  - Fire reasserting in HOLD → FIRE; count reloads on the next exit from FIRE.
- **WIN:** winbuzz=1.
- **DOOR:**
  - The lowest-index open door wins and drives door_open/door_idx.
  - The selection is re-evaluated every cycle, so a lower-index door opening preempts the current one.
  - door_idx=0 and door_open=0 in every state other than DOOR.
- **Thermostat** (active when state ∉ {FIRE, HOLD}):
  - heater: set when temp ≤ HEAT_ON, clear when temp ≥ HEAT_OFF, otherwise hold.
  - cooler: same rule against COOL_ON/COOL_OFF.
  - The threshold ordering guarantees heater and cooler are never both 1.
- **Widths:** all comparisons are unsigned at TEMP_W bits. Thresholds are truncated to TEMP_W. count is $clog2(BUZZ_CYC+1) bits.

## Timing
- All outputs are registered and Moore-decoded from the next state, so they update on the same edge as state.
- **Sensor path latency:** raw change sampled at edge 0 → synced at edge 1 → filtered at edge DEB_CYC+1 → state and outputs at edge DEB_CYC+2.
- **Temperature path latency:** ST sampled at edge 0 → heater/cooler at edge 1.
- **Glitch rejection:** a pulse shorter than DEB_CYC synced cycles never reaches the state machine.
- **HOLD length:** alarmbuzz stays 1 for exactly BUZZ_CYC cycles after FIRE exits, absent ack.
- **alarm_ack:** sampled in HOLD only; ignored in all other states.
- **Simultaneous events:** fire, window and door changing on the same cycle resolve strictly by the priority list.
- **Reset mid-operation:** asserting Rst during FIRE or HOLD clears alarmbuzz asynchronously. After release, debounce restarts from 0, so a persistent fire re-enters FIRE DEB_CYC+2 edges later.

## Structure
- Package smart_home_pkg holds:
  - the state enum with the fixed codes above
  - the STATE_W=3 constant
  - a function checking threshold ordering
- Sub-module sensor_debounce holds the synchroniser and debounce counter for one bit, parametrised by DEB_CYC. It is instantiated N_DOORS+2 times.
- The top level holds the FSM, the HOLD counter, the door priority encoder and the thermostat.

## Test plan
- **Door timing:** defaults, Rst released, SD=2'b01 at edge 0 → door_open=01, display=001 at edge 6; no change before that edge.
- **Glitch rejection:** SW pulse of 3 cycles → winbuzz stays 0, display stays 000.
- **Fire over window, then hold:**
  - SFA=1 while SW=1 and ST=40 with heater=1 → display=011, alarmbuzz=1, heater=0.
  - SFA=0 → HOLD, with alarmbuzz=1 for 16 cycles, then display=100 (window still open).
- **Ack and re-fire in HOLD:**
  - alarm_ack on the 5th HOLD cycle → IDLE next edge.
  - In a second run, SFA reasserting in HOLD → FIRE, and a full 16-cycle HOLD follows.
- **Thermostat hysteresis:** ST sequence 60, 50, 53, 55, 82, 85, 81, 80 → heater 0, 1, 1, 0, 0, 0, 0, 0 and cooler 0, 0, 0, 0, 0, 1, 1, 0, each one edge after ST.
- **Door preemption and reset:**
  - N_DOORS=4: SD=1000 → door_idx=3.
  - Then SD=1010 → door_idx=1.
  - Rst pulse mid-DOOR → all outputs 0 immediately and during reset.

Source files
------------

// File: rtl/smart_home_pkg.sv
// Shared state encoding and elaboration helpers for the smart-home HVAC controller.
package smart_home_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'b000,
    ST_DOOR = 3'b001,
    ST_FIRE = 3'b011,
    ST_WIN  = 3'b100,
    ST_HOLD = 3'b101
  } state_t;

  // Strict ordering keeps heater and cooler mutually exclusive.
  function automatic bit thresholds_ok(input int heat_on, input int heat_off,
                                       input int cool_off, input int cool_on);
    return (heat_on < heat_off) && (heat_off < cool_off) && (cool_off < cool_on);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus consecutive-disagreement debounce for one sensor bit.
module sensor_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic Rst,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // filt follows sync2 on the DEB_CYC-th consecutive cycle they disagree.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      filt  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/smart_home_hvac_ctrl.sv
// Sensor arbitration FSM with alarm hold, door priority encoder and hysteresis thermostat.
//
// state | meaning
// IDLE  | nothing open, no fire
// DOOR  | lowest-index open door reported on door_open/door_idx
// WIN   | window open, winbuzz on
// FIRE  | fire present, alarm on, HVAC forced off
// HOLD  | fire cleared, alarm held for BUZZ_CYC cycles or until alarm_ack
module smart_home_hvac_ctrl #(
  parameter int N_DOORS  = 2,
  parameter int TEMP_W   = 7,
  parameter int HEAT_ON  = 50,
  parameter int HEAT_OFF = 55,
  parameter int COOL_ON  = 85,
  parameter int COOL_OFF = 80,
  parameter int DEB_CYC  = 4,
  parameter int BUZZ_CYC = 16
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic [N_DOORS-1:0]         SD,
  input  logic                       SW,
  input  logic                       SFA,
  input  logic                       alarm_ack,
  input  logic [TEMP_W-1:0]          ST,
  output logic [N_DOORS-1:0]         door_open,
  output logic [$clog2(N_DOORS):0]   door_idx,
  output logic                       winbuzz,
  output logic                       alarmbuzz,
  output logic                       heater,
  output logic                       cooler,
  output logic [2:0]                 display
);

  import smart_home_pkg::*;

  localparam int IDX_W = $clog2(N_DOORS) + 1;
  localparam int CNT_W = $clog2(BUZZ_CYC + 1);
  localparam logic [CNT_W-1:0]  BUZZ_LOAD  = CNT_W'(BUZZ_CYC);
  localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
  localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);

  if (!thresholds_ok(HEAT_ON, HEAT_OFF, COOL_OFF, COOL_ON)) begin : g_bad_thresholds
    $error("smart_home_hvac_ctrl: need HEAT_ON < HEAT_OFF < COOL_OFF < COOL_ON");
  end
  if (N_DOORS < 1 || N_DOORS > 8 || DEB_CYC < 1 || BUZZ_CYC < 1) begin : g_bad_params
    $error("smart_home_hvac_ctrl: N_DOORS must be 1..8, DEB_CYC and BUZZ_CYC at least 1");
  end

  logic [N_DOORS-1:0] door_f;
  logic               win_f;
  logic               fire_f;

  for (genvar i = 0; i < N_DOORS; i++) begin : g_door_deb
    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (clk),
      .Rst  (Rst),
      .raw  (SD[i]),
      .filt (door_f[i])
    );
  end

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_win_deb (
    .clk  (clk),
    .Rst  (Rst),
    .raw  (SW),
    .filt (win_f)
  );

  sensor_debounce #(.DEB_CYC(DEB_CYC)) u_fire_deb (
    .clk  (clk),
    .Rst  (Rst),
    .raw  (SFA),
    .filt (fire_f)
  );

  logic [TEMP_W-1:0] temp_q;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      temp_q <= '0;
    end else begin
      temp_q <= ST;
    end
  end

  logic               door_any;
  logic [N_DOORS-1:0] sel_oh;
  logic [IDX_W-1:0]   sel_idx;

  // Scan high to low so the lowest-index open door is written last and wins.
  always_comb begin
    door_any = |door_f;
    sel_oh   = '0;
    sel_idx  = '0;
    for (int i = N_DOORS - 1; i >= 0; i--) begin
      if (door_f[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;

  // Leaving FIRE always passes through HOLD; the rest is a strict priority list.
  always_comb begin
    state_nxt = ST_IDLE;
    if (fire_f) begin
      state_nxt = ST_FIRE;
    end else if (state == ST_FIRE) begin
      state_nxt = ST_HOLD;
    end else if (state == ST_HOLD && hold_cnt > CNT_W'(1) && !alarm_ack) begin
      state_nxt = ST_HOLD;
    end else if (win_f) begin
      state_nxt = ST_WIN;
    end else if (door_any) begin
      state_nxt = ST_DOOR;
    end
  end

  logic heat_nxt;
  logic cool_nxt;
  logic alarm_nxt;

  always_comb begin
    alarm_nxt = (state_nxt == ST_FIRE) || (state_nxt == ST_HOLD);
    heat_nxt  = heater;
    cool_nxt  = cooler;
    if (temp_q <= HEAT_ON_T) begin
      heat_nxt = 1'b1;
    end else if (temp_q >= HEAT_OFF_T) begin
      heat_nxt = 1'b0;
    end
    if (temp_q >= COOL_ON_T) begin
      cool_nxt = 1'b1;
    end else if (temp_q <= COOL_OFF_T) begin
      cool_nxt = 1'b0;
    end
    if (alarm_nxt) begin
      heat_nxt = 1'b0;
      cool_nxt = 1'b0;
    end
  end

  // Outputs are decoded from state_nxt so they change on the same edge as state.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      display   <= '0;
      door_open <= '0;
      door_idx  <= '0;
      winbuzz   <= 1'b0;
      alarmbuzz <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_HOLD) begin
        hold_cnt <= (state == ST_HOLD) ? hold_cnt - 1'b1 : BUZZ_LOAD;
      end
      display   <= state_nxt;
      door_open <= (state_nxt == ST_DOOR) ? sel_oh : '0;
      door_idx  <= (state_nxt == ST_DOOR) ? sel_idx : '0;
      winbuzz   <= (state_nxt == ST_WIN);
      alarmbuzz <= alarm_nxt;
      heater    <= heat_nxt;
      cooler    <= cool_nxt;
    end
  end

endmodule

// File: tb/tb_smart_home_hvac_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random run against a model.
module tb_smart_home_hvac_ctrl;

  localparam int ND   = 2;
  localparam int TW   = 7;
  localparam int DEB  = 4;
  localparam int BUZZ = 16;
  localparam int IW   = $clog2(ND) + 1;
  localparam int NS   = ND + 2;
  localparam int WIN_I  = ND;
  localparam int FIRE_I = ND + 1;
  localparam int NV   = 12;

  logic           clk = 1'b0;
  logic           Rst;
  logic [ND-1:0]  SD;
  logic           SW, SFA, alarm_ack;
  logic [TW-1:0]  ST;
  logic [ND-1:0]  door_open;
  logic [IW-1:0]  door_idx;
  logic           winbuzz, alarmbuzz, heater, cooler;
  logic [2:0]     display;

  logic [3:0]     sd4;
  logic [3:0]     door_open4;
  logic [2:0]     door_idx4;
  logic           winbuzz4, alarmbuzz4, heater4, cooler4;
  logic [2:0]     display4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smart_home_hvac_ctrl dut (
    .clk(clk), .Rst(Rst), .SD(SD), .SW(SW), .SFA(SFA), .alarm_ack(alarm_ack), .ST(ST),
    .door_open(door_open), .door_idx(door_idx), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .display(display)
  );

  smart_home_hvac_ctrl #(.N_DOORS(4)) dut4 (
    .clk(clk), .Rst(Rst), .SD(sd4), .SW(SW), .SFA(SFA), .alarm_ack(alarm_ack), .ST(ST),
    .door_open(door_open4), .door_idx(door_idx4), .winbuzz(winbuzz4), .alarmbuzz(alarmbuzz4),
    .heater(heater4), .cooler(cooler4), .display(display4)
  );

  typedef struct packed {
    logic [ND-1:0] sd;
    logic          sw;
    logic          sfa;
    logic [TW-1:0] st;
    int            cyc;
    logic [2:0]    disp;
    logic [ND-1:0] dopen;
    logic [IW-1:0] didx;
    logic          wb, ab, h, c;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [10:0] mk(input logic [2:0] d, input logic [ND-1:0] o,
                                     input logic [IW-1:0] x, input logic wb, input logic ab,
                                     input logic h, input logic c);
    return {d, o, x, wb, ab, h, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string name, input logic [10:0] exp);
    check(name, {21'd0, display, door_open, door_idx, winbuzz, alarmbuzz, heater, cooler}, {21'd0, exp});
  endtask

  // Reference model: spec rules evaluated once per rising edge.
  localparam int M_IDLE = 0, M_DOOR = 1, M_WIN = 2, M_FIRE = 3, M_HOLD = 4;
  logic           m_sync1 [NS];
  logic           m_sync2 [NS];
  logic           m_filt  [NS];
  logic [DEB-1:0] m_hist  [NS];
  logic [TW-1:0]  m_temp;
  int             m_state, m_hold_left;
  logic           m_heat, m_cool;
  logic [ND-1:0]  m_oh;
  logic [IW-1:0]  m_idx;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_sync1[i] = 1'b0; m_sync2[i] = 1'b0; m_filt[i] = 1'b0; m_hist[i] = '0;
    end
    m_temp = '0; m_state = M_IDLE; m_hold_left = 0;
    m_heat = 1'b0; m_cool = 1'b0; m_oh = '0; m_idx = '0;
  endtask

  task automatic model_edge();
    logic [NS-1:0] raw;
    int ns;
    bit found;
    raw = {SFA, SW, SD};
    found = 0; m_oh = '0; m_idx = '0;
    for (int i = 0; i < ND; i++) begin
      if (!found && m_filt[i]) begin
        found = 1; m_oh[i] = 1'b1; m_idx = IW'(i);
      end
    end
    if (m_filt[FIRE_I]) ns = M_FIRE;
    else if (m_state == M_FIRE) begin ns = M_HOLD; m_hold_left = BUZZ; end
    else if (m_state == M_HOLD && m_hold_left > 1 && !alarm_ack) begin
      ns = M_HOLD; m_hold_left--;
    end
    else if (m_filt[WIN_I]) ns = M_WIN;
    else if (found) ns = M_DOOR;
    else ns = M_IDLE;
    if (ns == M_FIRE || ns == M_HOLD) begin
      m_heat = 1'b0; m_cool = 1'b0;
    end else begin
      if (m_temp <= 50) m_heat = 1'b1; else if (m_temp >= 55) m_heat = 1'b0;
      if (m_temp >= 85) m_cool = 1'b1; else if (m_temp <= 80) m_cool = 1'b0;
    end
    m_state = ns;
    for (int i = 0; i < NS; i++) begin
      m_hist[i] = {m_hist[i][DEB-2:0], m_sync2[i]};
      if (m_hist[i] == {DEB{~m_filt[i]}}) m_filt[i] = m_sync2[i];
      m_sync2[i] = m_sync1[i];
      m_sync1[i] = raw[i];
    end
    m_temp = ST;
  endtask

  function automatic logic [10:0] model_obs();
    logic [2:0] d;
    case (m_state)
      M_IDLE:  d = 3'b000;
      M_DOOR:  d = 3'b001;
      M_WIN:   d = 3'b100;
      M_FIRE:  d = 3'b011;
      default: d = 3'b101;
    endcase
    return mk(d, (m_state == M_DOOR) ? m_oh : '0, (m_state == M_DOOR) ? m_idx : '0,
              m_state == M_WIN, m_state == M_FIRE || m_state == M_HOLD, m_heat, m_cool);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b0; SD = '0; SW = 1'b0; SFA = 1'b0; alarm_ack = 1'b0; ST = 7'd60; sd4 = '0;
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    // st register comes out of reset at 0, so heater blips for one cycle
    repeat (3) @(negedge clk);
  endtask

  initial begin
    Rst = 1'b0; SD = '0; SW = 1'b0; SFA = 1'b0; alarm_ack = 1'b0; ST = 7'd60; sd4 = '0;
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 7'd60, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 7'd50, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 7'd53, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 1'b0, 1'b0, 7'd55, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 1'b0, 1'b0, 7'd82, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 7'd85, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, 1'b0, 1'b0, 7'd81, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 7'd80, 2, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 1'b0, 1'b0, 7'd60, 8, 3'b001, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 7'd60, 8, 3'b001, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 1'b0, 7'd60, 8, 3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 1'b1, 1'b1, 7'd85, 8, 3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    check_obs("reset_state", 11'd0);

    // door latency: visible at edge DEB+2, nothing before
    do_reset();
    SD = 2'b01;
    for (int e = 0; e < DEB + 2; e++) begin
      @(negedge clk);
      check("door_early", {29'd0, display} | {27'd0, door_open, 3'b000}, 32'd0);
    end
    @(negedge clk);
    check_obs("door_edge6", mk(3'b001, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    SD = 2'b00;
    repeat (8) @(negedge clk);
    check_obs("door_closed", 11'd0);

    // 3-cycle window glitch is rejected
    SW = 1'b1;
    repeat (3) @(negedge clk);
    SW = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      check("glitch_win", {28'd0, display, winbuzz}, 32'd0);
    end

    // fire over window, then full hold, then back to window
    ST = 7'd40; SW = 1'b1;
    repeat (8) @(negedge clk);
    check_obs("win_heat", mk(3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
    SFA = 1'b1;
    repeat (7) @(negedge clk);
    check_obs("fire_over_win", mk(3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    SFA = 1'b0;
    repeat (6) @(negedge clk);
    check_obs("fire_before_exit", mk(3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int e = 0; e < BUZZ; e++) begin
      @(negedge clk);
      check_obs($sformatf("hold_cycle%0d", e), mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
    check_obs("hold_to_win", mk(3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));

    // ack on the 5th hold cycle
    SW = 1'b0; ST = 7'd60;
    repeat (8) @(negedge clk);
    check_obs("idle_again", 11'd0);
    SFA = 1'b1;
    repeat (7) @(negedge clk);
    SFA = 1'b0;
    repeat (7) @(negedge clk);
    check_obs("ack_hold_entry", mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    check_obs("ack_hold_c5", mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check_obs("ack_exit", 11'd0);

    // ack ignored in FIRE; fire reasserting in HOLD restarts a full hold
    alarm_ack = 1'b1; SFA = 1'b1;
    repeat (7) @(negedge clk);
    check_obs("ack_in_fire", mk(3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    alarm_ack = 1'b0; SFA = 1'b0;
    repeat (7) @(negedge clk);
    check_obs("refire_hold", mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    SFA = 1'b1;
    repeat (6) @(negedge clk);
    check_obs("refire_wait", mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check_obs("refire_fire", mk(3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    SFA = 1'b0;
    repeat (6) @(negedge clk);
    for (int e = 0; e < BUZZ; e++) begin
      @(negedge clk);
      check_obs($sformatf("refire_hold%0d", e), mk(3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    @(negedge clk);
    check_obs("refire_end", 11'd0);

    // table of settled vectors: thermostat hysteresis and priority
    do_reset();
    for (int k = 0; k < NV; k++) begin
      SD = vecs[k].sd; SW = vecs[k].sw; SFA = vecs[k].sfa; ST = vecs[k].st;
      repeat (vecs[k].cyc) @(negedge clk);
      check_obs($sformatf("vec%0d", k), mk(vecs[k].disp, vecs[k].dopen, vecs[k].didx,
                                           vecs[k].wb, vecs[k].ab, vecs[k].h, vecs[k].c));
    end

    // async reset in FIRE, persistent fire re-enters after DEB+2 edges
    Rst = 1'b0;
    #1;
    check_obs("rst_async_fire", 11'd0);
    @(negedge clk);
    check_obs("rst_held", 11'd0);
    Rst = 1'b1;
    for (int e = 0; e < DEB + 2; e++) begin
      @(negedge clk);
      check("refire_after_rst_early", {28'd0, display, alarmbuzz}, 32'd0);
    end
    @(negedge clk);
    check("refire_after_rst", {28'd0, display, alarmbuzz}, {28'd0, 3'b011, 1'b1});

    // four-door preemption and reset mid-DOOR
    do_reset();
    sd4 = 4'b1000;
    repeat (8) @(negedge clk);
    check("door4_idx3", {22'd0, display4, door_open4, door_idx4}, {22'd0, 3'b001, 4'b1000, 3'd3});
    sd4 = 4'b1010;
    repeat (8) @(negedge clk);
    check("door4_preempt", {22'd0, display4, door_open4, door_idx4}, {22'd0, 3'b001, 4'b0010, 3'd1});
    Rst = 1'b0;
    #1;
    check("door4_rst_async", {18'd0, display4, door_open4, door_idx4, winbuzz4, alarmbuzz4, heater4, cooler4}, 32'd0);
    repeat (2) @(negedge clk);
    check("door4_rst_held", {18'd0, display4, door_open4, door_idx4, winbuzz4, alarmbuzz4, heater4, cooler4}, 32'd0);
    Rst = 1'b1;
    sd4 = '0;

    // random run against the model
    @(negedge clk);
    Rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 2 || $urandom_range(0, 499) == 0) Rst = 1'b0;
      else Rst = 1'b1;
      if (!Rst) model_reset();
      for (int i = 0; i < ND; i++) if ($urandom_range(0, 5) == 0) SD[i] = ~SD[i];
      if ($urandom_range(0, 9) == 0) SW = ~SW;
      if ($urandom_range(0, 39) == 0) SFA = ~SFA;
      alarm_ack = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) ST = TW'($urandom_range(30, 100));
      @(posedge clk);
      if (Rst) model_edge();
      @(negedge clk);
      check_obs("random", model_obs());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
